// File: rtl/seq_signed_divider.sv
// Sequential signed divider: a 2W-bit signed dividend divided by a W-bit signed
// divisor using one restoring step per clock on magnitudes, then a single
// sign-correction cycle that also raises the divide-by-zero and overflow flags.
//
// Handshake: the request (start with A/B) is taken only while the FSM is idle;
// busy rises on the accepting edge and stays high through the cycle in which
// ready pulses for one clock. Q/R/dbz/ovf are valid from the ready cycle on and
// hold until the next accepted request reaches its correction cycle.
module seq_signed_divider #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2*W-1:0]   A,
  input  logic [W-1:0]     B,
  output logic             ready,
  output logic             busy,
  output logic [W-1:0]     Q,
  output logic [W-1:0]     R,
  output logic             dbz,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(2 * W);
  localparam logic [CW-1:0] LAST_STEP = CW'(2 * W - 1);
  // Largest positive and negative quotient magnitudes that fit W signed bits.
  localparam logic [2*W-1:0] POS_MAX = {{(W + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic [2*W-1:0] NEG_MAX = {{W{1'b0}}, 1'b1, {(W - 1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  // Dividend magnitude: high bits shift out into the partial remainder while
  // quotient bits shift in at the bottom, so after 2W steps it holds |quotient|.
  logic [2*W-1:0] dvd_q, dvd_d;
  logic [W:0]     rem_q, rem_d;
  logic [W-1:0]   bmag_q, bmag_d;
  logic           qneg_q, qneg_d;
  logic           rneg_q, rneg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ready_q, ready_d;
  logic           busy_q, busy_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   rmd_q, rmd_d;
  logic           dbz_q, dbz_d;
  logic           ovf_q, ovf_d;

  // Datapath helpers for one restoring step and for the correction cycle.
  logic [W:0]     shifted;
  logic [W+1:0]   trial;
  logic           q_ovf;

  // Next-state and datapath computation for every register.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    bmag_d  = bmag_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    // The partial remainder stays below |B| <= 2^(W-1), so its top bit is
    // always zero before the shift and W+1 bits hold the shifted value.
    shifted = {rem_q[W-1:0], dvd_q[2*W-1]};
    trial   = {1'b0, shifted} - {2'b00, bmag_q};
    q_ovf   = qneg_q ? (dvd_q > NEG_MAX) : (dvd_q > POS_MAX);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Negation in full width yields the correct unsigned magnitude even
          // for the most negative operand values.
          dvd_d   = A[2*W-1] ? (-A) : A;
          bmag_d  = B[W-1] ? (-B) : B;
          qneg_d  = A[2*W-1] ^ B[W-1];
          rneg_d  = A[2*W-1];
          rem_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        if (!trial[W+1]) begin
          rem_d = trial[W:0];
          dvd_d = {dvd_q[2*W-2:0], 1'b1};
        end else begin
          rem_d = shifted;
          dvd_d = {dvd_q[2*W-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (bmag_q == '0) begin
          dbz_d = 1'b1;
          ovf_d = 1'b0;
          quo_d = '0;
          rmd_d = '0;
        end else if (q_ovf) begin
          dbz_d = 1'b0;
          ovf_d = 1'b1;
          quo_d = '0;
          rmd_d = '0;
        end else begin
          dbz_d = 1'b0;
          ovf_d = 1'b0;
          quo_d = qneg_q ? (-dvd_q[W-1:0]) : dvd_q[W-1:0];
          rmd_d = rneg_q ? (-rem_q[W-1:0]) : rem_q[W-1:0];
        end
        ready_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        ready_d = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Single register stage for FSM, datapath and outputs; reset abandons work.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      rem_q   <= '0;
      bmag_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      bmag_q  <= bmag_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign Q         = quo_q;
  assign R         = rmd_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider (W=8): directed sign/bound cases,
// divide-by-zero, ignored start, mid-operation reset and a few random requests.
module tb_seq_signed_divider;

  localparam int W = 8;
  localparam int LAT = 2 * W + 1;

  // Clock and reset
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [2*W-1:0]   A = '0;
  logic [W-1:0]     B = '0;
  logic             ready, busy, dbz, ovf;
  logic [W-1:0]     Q, R;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  seq_signed_divider #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .ready(ready), .busy(busy), .Q(Q), .R(R), .dbz(dbz), .ovf(ovf),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  int edge_n = 0;
  int ready_cnt = 0;

  // Expected {dbz, ovf, Q, R} per accepted request.
  logic [2*W+1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: truncating signed division with flag rules.
  function automatic logic [2*W+1:0] model(input logic [2*W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [W-1:0] qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) return {1'b1, 1'b0, {(2*W){1'b0}}};
    q = sa / sb;
    r = sa % sb;
    if (q > longint'((1 << (W - 1)) - 1) || q < -longint'(1 << (W - 1)))
      return {1'b0, 1'b1, {(2*W){1'b0}}};
    qv = q[W-1:0];
    rv = r[W-1:0];
    return {2'b00, qv, rv};
  endfunction

  // Scoreboard: compare outputs whenever ready is seen.
  always @(negedge clk) begin
    logic [2*W+1:0] e;
    if (!rst && ready) begin
      ready_cnt++;
      if (exp_q.size() == 0) begin
        check("spurious_ready", 32'(ready), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("Q",   32'(Q),   32'(e[2*W-1:W]));
        check("R",   32'(R),   32'(e[W-1:0]));
        check("dbz", 32'(dbz), 32'(e[2*W+1]));
        check("ovf", 32'(ovf), 32'(e[2*W]));
      end
    end
  end

  // Driver: present a request so that it is accepted at the next edge (edge 0).
  task automatic start_op(input int a, input int b);
    logic [2*W-1:0] av;
    logic [W-1:0]   bv;
    av = (2*W)'(a);
    bv = W'(b);
    @(negedge clk);
    A = av;
    B = bv;
    start = 1'b1;
    exp_q.push_back(model(av, bv));
    @(posedge clk);
    edge_n = 0;
    #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("state_div", 32'(dbg_state), 32'd1);
  endtask

  // Wait (bounded) for ready; check its edge, its width and busy falling.
  task automatic wait_ready();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      edge_n++;
      #1;
      if (ready) seen = 1'b1;
    end
    check("ready_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("latency", 32'(edge_n), 32'(LAT));
      check("busy_at_ready", 32'(busy), 32'd1);
      @(posedge clk);
      edge_n++;
      #1;
      check("ready_drop", 32'(ready), 32'd0);
      check("busy_drop", 32'(busy), 32'd0);
    end
  endtask

  task automatic step_edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      edge_n++;
    end
  endtask

  int ta[12] = '{21, -7, 7, 49, 225, -128, 128, -32768, -32768, -16384, 16256, 100};
  int tb[12] = '{3, 2, -2, -7, 15, 1, 1, -1, -128, -128, -128, 0};

  // Main stimulus sequence.
  initial begin
    int cnt_before;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_Q", 32'(Q), 32'd0);
    check("rst_R", 32'(R), 32'd0);
    check("rst_dbz", 32'(dbz), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // Directed table: signs, bounds, divide by zero.
    for (int i = 0; i < 12; i++) begin
      start_op(ta[i], tb[i]);
      wait_ready();
    end

    // Random requests.
    for (int i = 0; i < 8; i++) begin
      start_op(int'($urandom_range(0, 65535)), int'($urandom_range(0, 255)));
      wait_ready();
    end

    // start re-pulsed at edge 5 with other operands must be ignored.
    cnt_before = ready_cnt;
    start_op(21, 3);
    step_edges(4);
    #1;
    A = (2*W)'(-100);
    B = W'(7);
    start = 1'b1;
    step_edges(1);
    #1;
    start = 1'b0;
    wait_ready();
    step_edges(20);
    check("single_ready", 32'(ready_cnt - cnt_before), 32'd1);

    // Reset at edge 8 mid-DIV abandons the request; new start at edge 10.
    cnt_before = ready_cnt;
    start_op(100, 7);
    step_edges(7);
    #1;
    rst = 1'b1;
    step_edges(1);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_Q", 32'(Q), 32'd0);
    check("midrst_R", 32'(R), 32'd0);
    check("midrst_flags", 32'({dbz, ovf}), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    step_edges(1);
    start_op(-77, 5);
    wait_ready();
    step_edges(20);
    check("ready_after_rst", 32'(ready_cnt - cnt_before), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
